// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, instruction field positions,
// fetch FSM states and the default reset PC.
package mips_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FuncAdd = 6'h20;
  localparam logic [5:0] FuncSub = 6'h22;
  localparam logic [5:0] FuncAnd = 6'h24;
  localparam logic [5:0] FuncOr  = 6'h25;
  localparam logic [5:0] FuncSlt = 6'h2a;

  // Instruction field bit positions
  localparam int unsigned OpMsb     = 31;
  localparam int unsigned OpLsb     = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned RdMsb     = 15;
  localparam int unsigned RdLsb     = 11;
  localparam int unsigned FuncMsb   = 5;
  localparam int unsigned FuncLsb   = 0;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;
  localparam int unsigned TargetMsb = 25;
  localparam int unsigned TargetLsb = 0;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StValid
  } fetch_state_e;

  // Sign-extended word offset of a branch immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection for a retiring instruction; jump wins over a taken branch.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic unused_op;
  assign unused_op = ^instr[OpMsb:OpLsb];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[TargetMsb:TargetLsb], 2'b00};
    end else if (branch_taken) begin
      // Carry out of bit 31 is dropped so targets wrap modulo 2^32.
      next_pc = pc_plus4 + branch_offset(instr[ImmMsb:ImmLsb]);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction over a req/ready
// handshake and presents the held instruction and its decoded fields downstream.
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic        jump
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  next_pc;
  logic         capture;
  logic         advance;

  assign capture = (state_q == StReq) && imem_ready;
  assign advance = (state_q == StValid) && retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StReq;
      StReq:   if (imem_ready) state_d = StValid;
      StValid: if (retire) state_d = StReq;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == StReq);
    inst_valid = (state_q == StValid);
  end

  // Reset has priority, so a retire in the reset cycle never moves the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (capture) instr_q <= imem_rdata;
      if (advance) pc_q <= next_pc;
    end
  end

  npc_calc u_npc_calc (
    .pc_plus4     (pc_plus4),
    .instr        (instr_q),
    .branch_taken (branch_taken),
    .jump         (jump),
    .next_pc      (next_pc)
  );

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[OpMsb:OpLsb];
  assign func      = instr_q[FuncMsb:FuncLsb];
  assign rs        = instr_q[RsMsb:RsLsb];
  assign rt        = instr_q[RtMsb:RtLsb];
  assign rd        = instr_q[RdMsb:RdLsb];
  assign imm16     = instr_q[ImmMsb:ImmLsb];

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: three instances with different reset PCs, exercised one
// at a time; a negedge monitor checks fetch addresses and presented instructions.
module tb_inst_fetch;

  localparam int unsigned NumDut = 3;
  localparam logic [31:0] ResetPcs [NumDut]   = '{32'h0000_0000, 32'h4000_0000, 32'hFFFF_FFFC};
  localparam logic [31:0] ResetPcP4s [NumDut] = '{32'h0000_0004, 32'h4000_0004, 32'h0000_0000};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [15:0] imm;
  } inst_exp_t;

  logic        clk = 1'b0;
  logic        rst          [NumDut];
  logic        imem_req     [NumDut];
  logic [31:0] imem_addr    [NumDut];
  logic        imem_ready   [NumDut];
  logic [31:0] imem_rdata   [NumDut];
  logic        inst_valid   [NumDut];
  logic [31:0] instr        [NumDut];
  logic [5:0]  op           [NumDut];
  logic [5:0]  func         [NumDut];
  logic [4:0]  rs           [NumDut];
  logic [4:0]  rt           [NumDut];
  logic [4:0]  rd           [NumDut];
  logic [15:0] imm16        [NumDut];
  logic [31:0] pc           [NumDut];
  logic [31:0] pc_plus4     [NumDut];
  logic        retire       [NumDut];
  logic        branch_taken [NumDut];
  logic        jump         [NumDut];

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  inst_exp_t   exp_inst_q[$];
  logic        prev_req   [NumDut];
  logic        prev_valid [NumDut];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    inst_fetch #(.RESET_PC(ResetPcs[g])) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .imem_req     (imem_req[g]),
      .imem_addr    (imem_addr[g]),
      .imem_ready   (imem_ready[g]),
      .imem_rdata   (imem_rdata[g]),
      .inst_valid   (inst_valid[g]),
      .instr        (instr[g]),
      .op           (op[g]),
      .func         (func[g]),
      .rs           (rs[g]),
      .rt           (rt[g]),
      .rd           (rd[g]),
      .imm16        (imm16[g]),
      .pc           (pc[g]),
      .pc_plus4     (pc_plus4[g]),
      .retire       (retire[g]),
      .branch_taken (branch_taken[g]),
      .jump         (jump[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic inst_exp_t mk(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] p4, input logic [5:0] o,
                                   input logic [4:0] s, input logic [4:0] t,
                                   input logic [4:0] d, input logic [5:0] f,
                                   input logic [15:0] im);
    inst_exp_t e;
    e.instr = i; e.pc = p; e.pc4 = p4; e.op = o;
    e.rs = s; e.rt = t; e.rd = d; e.func = f; e.imm = im;
    return e;
  endfunction

  // Monitor: every new request and every newly presented instruction consumes one expectation.
  always @(negedge clk) begin
    for (int d = 0; d < NumDut; d++) begin
      if (imem_req[d] === 1'b1 && prev_req[d] !== 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: dut %0d requested %h with nothing expected", d,
                   imem_addr[d]);
        end else begin
          check("fetch_addr", imem_addr[d], exp_addr_q.pop_front());
        end
      end
      if (inst_valid[d] === 1'b1 && prev_valid[d] !== 1'b1) begin
        if (exp_inst_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: dut %0d presented %h with nothing expected", d,
                   instr[d]);
        end else begin
          inst_exp_t e;
          e = exp_inst_q.pop_front();
          check("instr", instr[d], e.instr);
          check("pc", pc[d], e.pc);
          check("pc_plus4", pc_plus4[d], e.pc4);
          check("op", {26'd0, op[d]}, {26'd0, e.op});
          check("rs", {27'd0, rs[d]}, {27'd0, e.rs});
          check("rt", {27'd0, rt[d]}, {27'd0, e.rt});
          check("rd", {27'd0, rd[d]}, {27'd0, e.rd});
          check("func", {26'd0, func[d]}, {26'd0, e.func});
          check("imm16", {16'd0, imm16[d]}, {16'd0, e.imm});
        end
      end
      prev_req[d]   = imem_req[d];
      prev_valid[d] = inst_valid[d];
    end
  end

  // Reset an instance, check its reset state and the one-cycle IDLE before the first request.
  task automatic start(input int d);
    rst[d] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_imem_req", {31'd0, imem_req[d]}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid[d]}, 32'd0);
    check("rst_pc", pc[d], ResetPcs[d]);
    check("rst_imem_addr", imem_addr[d], ResetPcs[d]);
    check("rst_pc_plus4", pc_plus4[d], ResetPcP4s[d]);
    check("rst_instr", instr[d], 32'd0);
    check("rst_fields", {op[d], func[d], rs[d], rt[d], rd[d]}, 32'd0);
    check("rst_imm16", {16'd0, imm16[d]}, 32'd0);
    exp_addr_q.push_back(ResetPcs[d]);
    @(posedge clk); #1;
    rst[d] = 1'b0;
    @(negedge clk);
    check("idle_no_req", {31'd0, imem_req[d]}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, imem_req[d]}, 32'd1);
  endtask

  // Answer the pending request after `waits` cycles of stall.
  task automatic serve(input int d, input logic [31:0] addr, input inst_exp_t e,
                       input int waits);
    int n = 0;
    while (imem_req[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (imem_req[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_timeout: dut %0d no request for %h", d, addr);
      return;
    end
    for (int i = 0; i < waits; i++) begin
      check("stall_req_held", {31'd0, imem_req[d]}, 32'd1);
      check("stall_addr", imem_addr[d], addr);
      check("stall_valid_low", {31'd0, inst_valid[d]}, 32'd0);
      @(negedge clk);
    end
    exp_inst_q.push_back(e);
    imem_ready[d] = 1'b1;
    imem_rdata[d] = e.instr;
    @(posedge clk); #1;
    imem_ready[d] = 1'b0;
    imem_rdata[d] = 32'h0;
    @(negedge clk);
    check("fetch_latency", {31'd0, inst_valid[d]}, 32'd1);
  endtask

  task automatic retire_inst(input int d, input logic br, input logic jmp,
                             input logic [31:0] next_addr);
    exp_addr_q.push_back(next_addr);
    retire[d]       = 1'b1;
    branch_taken[d] = br;
    jump[d]         = jmp;
    @(posedge clk); #1;
    retire[d]       = 1'b0;
    branch_taken[d] = 1'b0;
    jump[d]         = 1'b0;
    @(negedge clk);
    check("retire_to_req", {31'd0, imem_req[d]}, 32'd1);
    check("retire_valid_low", {31'd0, inst_valid[d]}, 32'd0);
  endtask

  initial begin
    inst_exp_t addi_i, j_i, beq_i;
    for (int d = 0; d < NumDut; d++) begin
      rst[d] = 1'b1; imem_ready[d] = 1'b0; imem_rdata[d] = 32'h0;
      retire[d] = 1'b0; branch_taken[d] = 1'b0; jump[d] = 1'b0;
      prev_req[d] = 1'b0; prev_valid[d] = 1'b0;
    end
    addi_i = mk(32'h2009_0005, 32'h0, 32'h4, 6'h08, 5'd0, 5'd9, 5'd0, 6'h05, 16'h0005);
    j_i    = mk(32'h0800_0004, 32'h4, 32'h8, 6'h02, 5'd0, 5'd0, 5'd0, 6'h04, 16'h0004);
    beq_i  = mk(32'h1000_FFFC, 32'h10, 32'h14, 6'h04, 5'd0, 5'd0, 5'd31, 6'h3C, 16'hFFFC);

    // Instance 0: RESET_PC = 0
    start(0);
    serve(0, 32'h0, addi_i, 0);
    retire_inst(0, 1'b0, 1'b0, 32'h4);
    serve(0, 32'h4, j_i, 2);
    retire_inst(0, 1'b0, 1'b1, 32'h10);
    serve(0, 32'h10, beq_i, 0);
    retire_inst(0, 1'b1, 1'b0, 32'h4);
    serve(0, 32'h4, j_i, 1);
    retire_inst(0, 1'b0, 1'b1, 32'h10);
    serve(0, 32'h10, beq_i, 0);
    retire_inst(0, 1'b0, 1'b0, 32'h14);

    // Reset mid-REQ, with a stale response during the following IDLE cycle.
    rst[0] = 1'b1;
    exp_addr_q.push_back(32'h0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    imem_ready[0] = 1'b1;
    imem_rdata[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_drops_req", {31'd0, imem_req[0]}, 32'd0);
    check("rst_clears_instr", instr[0], 32'd0);
    check("rst_restores_pc", pc[0], 32'h0);
    @(posedge clk); #1;
    imem_ready[0] = 1'b0;
    imem_rdata[0] = 32'h0;
    @(negedge clk);
    check("stale_resp_dropped", {31'd0, inst_valid[0]}, 32'd0);
    check("restart_req", {31'd0, imem_req[0]}, 32'd1);
    serve(0, 32'h0, addi_i, 0);

    // Reset and retire in the same cycle: reset wins.
    rst[0] = 1'b1;
    retire[0] = 1'b1;
    exp_addr_q.push_back(32'h0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    retire[0] = 1'b0;
    @(negedge clk);
    check("rst_beats_retire", pc[0], 32'h0);
    check("rst_retire_no_req", {31'd0, imem_req[0]}, 32'd0);
    @(negedge clk);
    check("rst_retire_req", {31'd0, imem_req[0]}, 32'd1);
    rst[0] = 1'b1;

    // Instance 1: jump and branch together at 0x4000_0000, jump wins.
    start(1);
    serve(1, 32'h4000_0000,
          mk(32'h0800_0100, 32'h4000_0000, 32'h4000_0004, 6'h02, 5'd0, 5'd0, 5'd0, 6'h00,
             16'h0100), 0);
    retire_inst(1, 1'b1, 1'b1, 32'h4000_0400);
    rst[1] = 1'b1;

    // Instance 2: sequential wrap from 0xFFFF_FFFC, then a backward branch that wraps.
    start(2);
    serve(2, 32'hFFFF_FFFC,
          mk(32'h0000_0020, 32'hFFFF_FFFC, 32'h0, 6'h00, 5'd0, 5'd0, 5'd0, 6'h20, 16'h0020), 1);
    retire_inst(2, 1'b0, 1'b0, 32'h0);
    serve(2, 32'h0,
          mk(32'h1000_FFFE, 32'h0, 32'h4, 6'h04, 5'd0, 5'd0, 5'd31, 6'h3E, 16'hFFFE), 0);
    retire_inst(2, 1'b1, 1'b0, 32'hFFFF_FFFC);
    rst[2] = 1'b1;

    @(negedge clk);
    check("queues_drained", exp_addr_q.size() + exp_inst_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
